// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload + valid with flush, bubble insertion and NOP substitution.
// Optional stall/bubble performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int                DATA_W    = 110,
    parameter int                STALL_W   = 6,
    parameter int                STAGE_IDX = 3,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               out_valid_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               bubble_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam int DN_IDX = STAGE_IDX + 1;

    logic up, dn;
    logic do_flush, do_bubble, do_load, do_hold;

    assign up = stall_i[STAGE_IDX];
    assign dn = stall_i[DN_IDX];

    // Mutually exclusive edge actions in priority order; flush beats any stall.
    assign do_flush  = flush_i;
    assign do_bubble = !flush_i && up && !dn;
    assign do_load   = !flush_i && !up;
    assign do_hold   = !flush_i && up && dn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= NOP_VALUE;
            bubble_o    <= 1'b0;
        end else if (do_flush || do_bubble) begin
            out_valid_o <= 1'b0;
            out_data_o  <= NOP_VALUE;
            bubble_o    <= 1'b1;
        end else if (do_load) begin
            out_valid_o <= in_valid_i;
            out_data_o  <= in_valid_i ? in_data_i : NOP_VALUE;
            bubble_o    <= 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    // Both counters saturate; at most one of them moves per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (do_hold && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if ((do_flush || do_bubble) && bubble_cnt_q != {CNT_W{1'b1}})
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

    // Upstream running while downstream stalls would overwrite an entry nobody consumed.
    illegal_stall_a: assert property (@(posedge clk) disable iff (!rst_n) !(do_load && dn));

    // A loaded payload (dn=0) leaving `do_load` unused otherwise is fine; hold is the implicit else.
    logic unused_hold;
    assign unused_hold = do_hold;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed test-plan sequence followed by random traffic.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_stage_reg;

    localparam int DW = 110;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;

    logic          o_valid, o_bubble, o2_valid, o2_bubble;
    logic [DW-1:0] o_data, o2_data;
    logic [15:0]   s_cnt, b_cnt;
    logic [1:0]    s_cnt2, b_cnt2;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data),
        .out_valid_o(o_valid), .out_data_o(o_data), .bubble_o(o_bubble),
        .stall_cnt_o(s_cnt), .bubble_cnt_o(b_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(SW), .STAGE_IDX(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_data_i(in_data),
        .out_valid_o(o2_valid), .out_data_o(o2_data), .bubble_o(o2_bubble),
        .stall_cnt_o(s_cnt2), .bubble_cnt_o(b_cnt2)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          bubble;
        int unsigned   scnt;
        int unsigned   bcnt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          pushed = 0;
    int          popped = 0;
    bit          stim_done = 0;

    // Reference state: what the stage should be holding after each edge.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_bubble = 1'b0;
    int unsigned   m_scnt = 0;
    int unsigned   m_bcnt = 0;

    function automatic int unsigned sat(int unsigned v, int w);
        int unsigned mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Drive one cycle of inputs and record the outcome the rules demand after the next edge.
    task automatic step(input logic r, input logic [SW-1:0] s, input logic f,
                        input logic v, input logic [DW-1:0] d);
        exp_t e;
        bit up, dn;
        @(negedge clk);
        rst_n = r; stall = s; flush = f; in_valid = v; in_data = d;
        up = s[3]; dn = s[4];
        if (!r) begin
            m_valid = 0; m_data = '0; m_bubble = 0; m_scnt = 0; m_bcnt = 0;
        end else if (f || (up && !dn)) begin
            m_valid = 0; m_data = '0; m_bubble = 1; m_bcnt++;
        end else if (!up) begin
            m_valid = v; m_data = v ? d : '0; m_bubble = 0;
        end else begin
            m_scnt++;
        end
        e.valid = m_valid; e.data = m_data; e.bubble = m_bubble;
        e.scnt = m_scnt; e.bcnt = m_bcnt;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: one registered result per edge, compared just after the edge.
    initial begin
        exp_t e;
        int unsigned es16, eb16, es2, eb2;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                popped++;
`ifdef PIPE_PERF_CNT_EN
                es16 = sat(e.scnt, 16); eb16 = sat(e.bcnt, 16);
                es2  = sat(e.scnt, 2);  eb2  = sat(e.bcnt, 2);
`else
                es16 = 0; eb16 = 0; es2 = 0; eb2 = 0;
`endif
                chk("out_valid",  128'(o_valid),  128'(e.valid));
                chk("out_data",   128'(o_data),   128'(e.data));
                chk("bubble",     128'(o_bubble), 128'(e.bubble));
                chk("stall_cnt",  128'(s_cnt),    128'(es16));
                chk("bubble_cnt", 128'(b_cnt),    128'(eb16));
                chk("sat_valid",  128'(o2_valid), 128'(e.valid));
                chk("sat_stall_cnt",  128'(s_cnt2), 128'(es2));
                chk("sat_bubble_cnt", 128'(b_cnt2), 128'(eb2));
            end
        end
    end

    initial begin
        logic [DW-1:0] dead, pat5a, p1234, paaaa;
        logic [SW-1:0] s;
        logic          f, r;
        dead  = DW'({4{32'hDEADBEEF}});
        pat5a = DW'({4{32'h5A5A5A5A}});
        p1234 = DW'(32'h1234);
        paaaa = DW'({4{32'hAAAA5555}});
        rst_n = 0; stall = '0; flush = 0; in_valid = 0; in_data = '0;

        // Reset with a live-looking input must still leave a clean bubble-free empty stage.
        step(0, 6'b000000, 0, 1, dead);
        step(0, 6'b000000, 0, 1, dead);
        // Load, then an invalid entry must come out as NOP.
        step(1, 6'b000000, 0, 1, pat5a);
        step(1, 6'b000000, 0, 0, dead);
        // Hold three cycles on 0x1234.
        step(1, 6'b000000, 0, 1, p1234);
        repeat (3) step(1, 6'b011000, 0, 1, rnd_data());
        // Single bubble, then a normal load.
        step(1, 6'b001000, 0, 1, rnd_data());
        step(1, 6'b000000, 0, 1, paaaa);
        // Flush overrides hold.
        step(1, 6'b011000, 1, 1, rnd_data());
        step(1, 6'b011000, 0, 1, rnd_data());
        step(1, 6'b000000, 0, 1, pat5a);
        // Drive bubble count past the 2-bit ceiling.
        repeat (5) step(1, 6'b001000, 0, 1, rnd_data());
        step(1, 6'b000000, 0, 1, p1234);
        // Reset in the middle of a stall drops all history.
        step(1, 6'b011000, 0, 1, rnd_data());
        step(0, 6'b011000, 0, 1, rnd_data());
        step(1, 6'b011000, 0, 1, rnd_data());

        // Random legal traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            s = SW'($urandom);
            if (!s[3]) s[4] = 1'b0;
            f = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) != 0);
            step(r, s, f, 1'($urandom), rnd_data());
        end
        stim_done = 1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 128'(popped), 128'(pushed));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
